// File: rtl/pipe_hazard_controller.sv
// Pipelined MIPS control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use / branch-operand stall, IF redirect and EX forwarding selects.
module pipe_hazard_controller #(
   parameter int REG_AW   = 5,
   parameter int ALU_OP_W = 3,
   parameter bit EN_BNE   = 1'b1,
   parameter bit EN_FWD   = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         instr,
   input  logic                equal,
   output logic                pc_write,
   output logic                ifid_write,
   output logic                if_flush,
   output logic [1:0]          pc_src,
   output logic                illegal,
   output logic [ALU_OP_W-1:0] ex_alu_op,
   output logic                ex_alu_sel,
   output logic                ex_reg_dst,
   output logic [1:0]          fwd_a,
   output logic [1:0]          fwd_b,
   output logic                mem_read,
   output logic                mem_write,
   output logic                wb_reg_write,
   output logic                wb_mem_to_reg,
   output logic [REG_AW-1:0]   wb_dst
);

   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic                alu_sel;
      logic                reg_dst;
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
      logic                mem_to_reg;
      logic [REG_AW-1:0]   dst;
      logic [REG_AW-1:0]   rs;
      logic [REG_AW-1:0]   rt;
   } id_ex_t;

   typedef struct packed {
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
      logic [REG_AW-1:0] dst;
   } ex_mem_t;

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic [REG_AW-1:0] dst;
   } mem_wb_t;

   id_ex_t  dec, idex;
   ex_mem_t exmem;
   mem_wb_t memwb;

   logic [5:0]        op, fn;
   logic [REG_AW-1:0] rs, rt, rd;
   logic is_nop, is_lw, is_sw, is_r, is_beq, is_bne, is_j;
   logic rd_rs, rd_rt;
   logic hit_ex, hit_mem, stall, take_br;

   assign op     = instr[31:26];
   assign fn     = instr[5:0];
   assign rs     = REG_AW'(instr[25:21]);
   assign rt     = REG_AW'(instr[20:16]);
   assign rd     = REG_AW'(instr[15:11]);
   assign is_nop = (instr == 32'd0);
   assign is_lw  = (op == 6'b100011);
   assign is_sw  = (op == 6'b101011);
   assign is_r   = (op == 6'b000000) && !is_nop;
   assign is_beq = (op == 6'b000100);
   assign is_bne = EN_BNE && (op == 6'b000101);
   assign is_j   = (op == 6'b000010);

   always_comb begin
      dec     = '0;
      illegal = 1'b0;
      rd_rs   = 1'b0;
      rd_rt   = 1'b0;
      unique case (1'b1)
         is_nop: ;
         is_lw: begin
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_sel    = 1'b1;
            dec.dst        = rt;
            rd_rs          = 1'b1;
         end
         is_sw: begin
            dec.mem_write = 1'b1;
            dec.alu_sel   = 1'b1;
            rd_rs         = 1'b1;
            rd_rt         = 1'b1;
         end
         is_r: begin
            dec.reg_write = 1'b1;
            dec.reg_dst   = 1'b1;
            dec.dst       = rd;
            rd_rs         = 1'b1;
            rd_rt         = 1'b1;
            case (fn)
               6'b100001: dec.alu_op = ALU_OP_W'(0);
               6'b100011: dec.alu_op = ALU_OP_W'(1);
               6'b100100: dec.alu_op = ALU_OP_W'(2);
               6'b100101: dec.alu_op = ALU_OP_W'(3);
               6'b101011: dec.alu_op = ALU_OP_W'(4);
               default: begin
                  dec     = '0;
                  illegal = 1'b1;
                  rd_rs   = 1'b0;
                  rd_rt   = 1'b0;
               end
            endcase
         end
         is_beq, is_bne: begin
            rd_rs = 1'b1;
            rd_rt = 1'b1;
         end
         is_j: ;
         default: illegal = 1'b1;
      endcase
      // unread operands are zeroed so they can never match a producer
      dec.rs = rd_rs ? rs : '0;
      dec.rt = rd_rt ? rt : '0;
   end

   assign hit_ex  = (idex.dst != '0) &&
                    ((rd_rs && rs == idex.dst) || (rd_rt && rt == idex.dst));
   assign hit_mem = (exmem.dst != '0) &&
                    ((rd_rs && rs == exmem.dst) || (rd_rt && rt == exmem.dst));

   always_comb begin
      stall = hit_ex && idex.mem_read;
      if ((is_beq || is_bne) &&
          ((hit_ex && idex.reg_write) || (hit_mem && exmem.mem_read)))
         stall = 1'b1;
      if (!EN_FWD &&
          ((hit_ex && idex.reg_write) || (hit_mem && exmem.reg_write)))
         stall = 1'b1;
   end

   assign take_br    = (is_beq && equal) || (is_bne && !equal);
   assign pc_write   = !stall;
   assign ifid_write = !stall;
   assign if_flush   = !stall && (take_br || is_j);
   assign pc_src     = stall   ? 2'd0 :
                       is_j    ? 2'd2 :
                       take_br ? 2'd1 : 2'd0;

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (EN_FWD) begin
         if (exmem.reg_write && exmem.dst != '0 && exmem.dst == idex.rs)
            fwd_a = 2'b10;
         else if (memwb.reg_write && memwb.dst != '0 && memwb.dst == idex.rs)
            fwd_a = 2'b01;
         if (exmem.reg_write && exmem.dst != '0 && exmem.dst == idex.rt)
            fwd_b = 2'b10;
         else if (memwb.reg_write && memwb.dst != '0 && memwb.dst == idex.rt)
            fwd_b = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex  <= '0;
         exmem <= '0;
         memwb <= '0;
      end else begin
         idex             <= stall ? '0 : dec;
         exmem.reg_write  <= idex.reg_write;
         exmem.mem_read   <= idex.mem_read;
         exmem.mem_write  <= idex.mem_write;
         exmem.mem_to_reg <= idex.mem_to_reg;
         exmem.dst        <= idex.dst;
         memwb.reg_write  <= exmem.reg_write;
         memwb.mem_to_reg <= exmem.mem_to_reg;
         memwb.dst        <= exmem.dst;
      end
   end

   assign ex_alu_op     = idex.alu_op;
   assign ex_alu_sel    = idex.alu_sel;
   assign ex_reg_dst    = idex.reg_dst;
   assign mem_read      = exmem.mem_read;
   assign mem_write     = exmem.mem_write;
   assign wb_reg_write  = memwb.reg_write;
   assign wb_mem_to_reg = memwb.mem_to_reg;
   assign wb_dst        = memwb.dst;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Scoreboard bench for pipe_hazard_controller: directed hazard sequences
// followed by random instruction streams against an in-order stage model.
module tb_pipe_hazard_controller;

  localparam bit EN_BNE = 1'b1;
  localparam bit EN_FWD = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        equal = 1'b0;

  logic       pc_write, ifid_write, if_flush, illegal;
  logic [1:0] pc_src, fwd_a, fwd_b;
  logic [2:0] ex_alu_op;
  logic       ex_alu_sel, ex_reg_dst, mem_read, mem_write;
  logic       wb_reg_write, wb_mem_to_reg;
  logic [4:0] wb_dst;

  always #5 clk = ~clk;

  pipe_hazard_controller #(
    .REG_AW(5), .ALU_OP_W(3),
    .EN_BNE(EN_BNE), .EN_FWD(EN_FWD)
  ) dut (
    .clk(clk), .rst(rst),
    .instr(instr), .equal(equal),
    .pc_write(pc_write),
    .ifid_write(ifid_write),
    .if_flush(if_flush),
    .pc_src(pc_src),
    .illegal(illegal),
    .ex_alu_op(ex_alu_op),
    .ex_alu_sel(ex_alu_sel),
    .ex_reg_dst(ex_reg_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dst(wb_dst)
  );

  typedef struct packed {
    logic rw, mr, mw, m2r, asel, rdst, br, bne, jmp, ill;
    logic [2:0] aop;
    logic [4:0] dst, sa, sb;
  } dec_t;

  typedef struct packed {
    logic pcw, ifw, fl, ill, asel, rdst, mr, mw, wrw, wm2r;
    logic [1:0] psrc, fa, fb;
    logic [2:0] aop;
    logic [4:0] wdst;
  } exp_t;

  exp_t q[$];
  dec_t ex_s = '0, mem_s = '0, wb_s = '0;
  logic m_stall = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic bad(input string n,
                     input logic [7:0] a,
                     input logic [7:0] e);
    n_fail++;
    $display("FAIL %s: got %0d expected %0d at %0t",
             n, a, e, $time);
  endtask

  function automatic dec_t mdl_decode(input logic [31:0] i);
    dec_t d;
    logic [5:0] op, fn;
    d  = '0;
    op = i[31:26];
    fn = i[5:0];
    if (i == 32'd0) return d;
    case (op)
      6'd35: begin
        d.rw = 1; d.mr = 1; d.m2r = 1; d.asel = 1;
        d.dst = i[20:16]; d.sa = i[25:21];
      end
      6'd43: begin
        d.mw = 1; d.asel = 1;
        d.sa = i[25:21]; d.sb = i[20:16];
      end
      6'd0: begin
        d.rw = 1; d.rdst = 1; d.dst = i[15:11];
        d.sa = i[25:21]; d.sb = i[20:16];
        case (fn)
          6'd33: d.aop = 3'd0;
          6'd35: d.aop = 3'd1;
          6'd36: d.aop = 3'd2;
          6'd37: d.aop = 3'd3;
          6'd43: d.aop = 3'd4;
          default: begin d = '0; d.ill = 1; end
        endcase
      end
      6'd4: begin
        d.br = 1; d.sa = i[25:21]; d.sb = i[20:16];
      end
      6'd5:
        if (EN_BNE) begin
          d.br = 1; d.bne = 1;
          d.sa = i[25:21]; d.sb = i[20:16];
        end else d.ill = 1;
      6'd2: d.jmp = 1;
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] mdl_fwd(input logic [4:0] s);
    if (!EN_FWD || s == 5'd0) return 2'b00;
    if (mem_s.rw && mem_s.dst == s) return 2'b10;
    if (wb_s.rw && wb_s.dst == s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input logic r,
                      input logic [31:0] ins,
                      input logic eq);
    dec_t id;
    exp_t e;
    logic st;
    logic [4:0] s;
    logic [1:0] tk;
    @(posedge clk);
    #1;
    rst = r; instr = ins; equal = eq;
    id = mdl_decode(ins);
    st = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? id.sa : id.sb;
      if (s != 5'd0) begin
        if (ex_s.rw && ex_s.dst == s &&
            (ex_s.mr || id.br || !EN_FWD))
          st = 1'b1;
        if (mem_s.rw && mem_s.dst == s &&
            ((id.br && mem_s.mr) || !EN_FWD))
          st = 1'b1;
      end
    end
    tk = id.jmp ? 2'd2 :
         (id.br && (id.bne ? !eq : eq)) ? 2'd1 : 2'd0;
    e.pcw  = !st;
    e.ifw  = !st;
    e.psrc = st ? 2'd0 : tk;
    e.fl   = !st && (tk != 2'd0);
    e.ill  = id.ill;
    e.aop  = ex_s.aop;
    e.asel = ex_s.asel;
    e.rdst = ex_s.rdst;
    e.fa   = mdl_fwd(ex_s.sa);
    e.fb   = mdl_fwd(ex_s.sb);
    e.mr   = mem_s.mr;
    e.mw   = mem_s.mw;
    e.wrw  = wb_s.rw;
    e.wm2r = wb_s.m2r;
    e.wdst = wb_s.dst;
    q.push_back(e);
    m_stall = st;
    if (r) begin
      ex_s = '0; mem_s = '0; wb_s = '0;
    end else begin
      wb_s  = mem_s;
      mem_s = ex_s;
      ex_s  = st ? '0 : id;
    end
  endtask

  task automatic issue(input logic [31:0] ins,
                       input logic eq);
    step(1'b0, ins, eq);
    for (int g = 0; m_stall && g < 8; g++)
      step(1'b0, ins, eq);
  endtask

  function automatic logic [31:0] mk_r(
    input logic [4:0] a, b, d,
    input logic [5:0] f);
    return {6'd0, a, b, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] mk_i(
    input logic [5:0] op,
    input logic [4:0] a, b,
    input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] a, b, d;
    logic [5:0] f;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: f = 6'd33;
      1: f = 6'd35;
      2: f = 6'd36;
      3: f = 6'd37;
      4: f = 6'd43;
      default: f = 6'd32;
    endcase
    case ($urandom_range(0, 9))
      0, 1: return mk_i(6'd35, a, b, 16'($urandom));
      2: return mk_i(6'd43, a, b, 16'($urandom));
      3, 4: return mk_r(a, b, d, f);
      5: return mk_i(6'd4, a, b, 16'($urandom));
      6: return mk_i(6'd5, a, b, 16'($urandom));
      7: return {6'd2, 26'($urandom)};
      8: return 32'd0;
      default: return mk_i(6'd8, a, b, 16'd1);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_chk += 15;
      if (pc_write !== e.pcw)
        bad("pc_write", 8'(pc_write), 8'(e.pcw));
      if (ifid_write !== e.ifw)
        bad("ifid_write", 8'(ifid_write), 8'(e.ifw));
      if (pc_src !== e.psrc)
        bad("pc_src", 8'(pc_src), 8'(e.psrc));
      if (if_flush !== e.fl)
        bad("if_flush", 8'(if_flush), 8'(e.fl));
      if (illegal !== e.ill)
        bad("illegal", 8'(illegal), 8'(e.ill));
      if (ex_alu_op !== e.aop)
        bad("ex_alu_op", 8'(ex_alu_op), 8'(e.aop));
      if (ex_alu_sel !== e.asel)
        bad("ex_alu_sel", 8'(ex_alu_sel), 8'(e.asel));
      if (ex_reg_dst !== e.rdst)
        bad("ex_reg_dst", 8'(ex_reg_dst), 8'(e.rdst));
      if (fwd_a !== e.fa)
        bad("fwd_a", 8'(fwd_a), 8'(e.fa));
      if (fwd_b !== e.fb)
        bad("fwd_b", 8'(fwd_b), 8'(e.fb));
      if (mem_read !== e.mr)
        bad("mem_read", 8'(mem_read), 8'(e.mr));
      if (mem_write !== e.mw)
        bad("mem_write", 8'(mem_write), 8'(e.mw));
      if (wb_reg_write !== e.wrw)
        bad("wb_reg_write", 8'(wb_reg_write), 8'(e.wrw));
      if (wb_mem_to_reg !== e.wm2r)
        bad("wb_mem_to_reg", 8'(wb_mem_to_reg), 8'(e.wm2r));
      if (wb_dst !== e.wdst)
        bad("wb_dst", 8'(wb_dst), 8'(e.wdst));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    step(1'b1, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    issue(mk_i(6'd35, 5'd1, 5'd2, 16'd0), 1'b0);
    issue(mk_r(5'd2, 5'd4, 5'd3, 6'd33), 1'b0);
    repeat (3) issue(32'd0, 1'b0);
    issue(mk_r(5'd1, 5'd1, 5'd2, 6'd33), 1'b0);
    issue(mk_r(5'd2, 5'd2, 5'd3, 6'd35), 1'b0);
    repeat (2) issue(32'd0, 1'b0);
    issue(mk_r(5'd1, 5'd1, 5'd0, 6'd33), 1'b0);
    issue(mk_r(5'd0, 5'd0, 5'd3, 6'd35), 1'b0);
    repeat (3) issue(32'd0, 1'b0);
    issue(mk_i(6'd4, 5'd1, 5'd2, 16'd8), 1'b1);
    issue(mk_i(6'd5, 5'd1, 5'd2, 16'd8), 1'b1);
    issue(mk_i(6'd5, 5'd1, 5'd2, 16'd8), 1'b0);
    issue(mk_i(6'd35, 5'd1, 5'd5, 16'd4), 1'b0);
    issue(mk_i(6'd4, 5'd5, 5'd6, 16'd8), 1'b1);
    issue({6'd2, 26'h123}, 1'b0);
    repeat (3) issue(32'd0, 1'b0);
    issue(mk_i(6'd35, 5'd1, 5'd2, 16'd0), 1'b0);
    step(1'b1, mk_r(5'd2, 5'd4, 5'd3, 6'd33), 1'b0);
    issue(mk_r(5'd2, 5'd4, 5'd3, 6'd33), 1'b0);
    repeat (3) issue(32'd0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0)
        step(1'b1, rnd_instr(), 1'($urandom_range(0, 1)));
      else
        issue(rnd_instr(), 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge clk);
    n_chk++;
    if (q.size() != 0)
      bad("scoreboard_drain", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
